// File: rtl/kronos_hcu_sb.sv
// Scoreboard hazard control unit: age-ordered queue of pending register writes,
// with registered per-operand hazard flags and producer ages for EX forwarding.
// Optional feature macro: KRONOS_HCU_RETIRE_BYPASS_EN (retiring entry skipped at check).
module kronos_hcu_sb #(
  parameter int              DEPTH       = 2,
  parameter int              NOPS        = 4,
  parameter logic [NOPS-1:0] OP_RS2_MASK = 4'b1010,
  localparam int             AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk_i,
  input  logic               rstz_i,
  input  logic               check_i,
  input  logic               fwd_vld_i,
  input  logic               retire_i,
  input  logic               flush_i,
  input  logic [4:0]         rd_i,
  input  logic [4:0]         rs1_i,
  input  logic [4:0]         rs2_i,
  input  logic               rd_write_i,
  input  logic [NOPS-1:0]    op_regrd_i,
  output logic [NOPS-1:0]    op_hazard_o,
  output logic               any_hazard_o,
  output logic [NOPS*AW-1:0] op_age_o,
  output logic [AW:0]        pend_count_o,
  output logic               full_o,
  output logic               err_o
);

`ifdef KRONOS_HCU_RETIRE_BYPASS_EN
  localparam bit RETIRE_BYPASS = 1'b1;
`else
  localparam bit RETIRE_BYPASS = 1'b0;
`endif

  // Entry 0 is the youngest; valid entries stay packed from index 0 upward.
  logic [DEPTH-1:0]      vld_q, vld_d;
  logic [DEPTH-1:0][4:0] rd_q, rd_d;
  logic [NOPS-1:0]       hz_q, hz_d;
  logic [NOPS*AW-1:0]    age_q, age_d;
  logic                  err_q, err_d;

  logic [AW:0]           cnt;
  logic                  full;
  logic [DEPTH-1:0]      oldest_oh;
  logic [DEPTH-1:0]      cmp_vld;
  logic [DEPTH-1:0]      vld_r;
  logic [NOPS-1:0]       new_hz;
  logic [NOPS*AW-1:0]    new_age;
  logic [4:0]            src;
  logic                  hit;
  logic [AW-1:0]         hit_age;
  logic                  retire_ok;
  logic                  underflow;
  logic                  alloc_req;
  logic                  alloc_ok;
  logic                  overflow;

  always_comb begin
    cnt = '0;
    for (int j = 0; j < DEPTH; j++) begin
      cnt = cnt + (AW+1)'(vld_q[j]);
    end
  end

  assign full = (cnt == (AW+1)'(DEPTH));

  always_comb begin
    oldest_oh = '0;
    for (int j = 0; j < DEPTH - 1; j++) begin
      oldest_oh[j] = vld_q[j] & ~vld_q[j+1];
    end
    oldest_oh[DEPTH-1] = vld_q[DEPTH-1];
  end

  // A write landing in the register file this edge needs no forwarding.
  assign cmp_vld = (RETIRE_BYPASS && retire_i) ? (vld_q & ~oldest_oh) : vld_q;

  always_comb begin
    new_hz  = '0;
    new_age = '0;
    src     = '0;
    hit     = 1'b0;
    hit_age = '0;
    for (int i = 0; i < NOPS; i++) begin
      src     = OP_RS2_MASK[i] ? rs2_i : rs1_i;
      hit     = 1'b0;
      hit_age = '0;
      // Scan oldest to youngest so the youngest match is the one kept.
      for (int j = DEPTH - 1; j >= 0; j--) begin
        if (cmp_vld[j] && (rd_q[j] == src)) begin
          hit     = 1'b1;
          hit_age = AW'(j);
        end
      end
      if (op_regrd_i[i] && (src != 5'd0) && hit) begin
        new_hz[i]            = 1'b1;
        new_age[i*AW +: AW]  = hit_age;
      end
    end
  end

  assign retire_ok = retire_i && (cnt != '0);
  assign underflow = retire_i && (cnt == '0);
  assign alloc_req = check_i && rd_write_i && (rd_i != 5'd0);
  assign alloc_ok  = alloc_req && (!full || retire_ok);
  assign overflow  = alloc_req && full && !retire_ok;
  assign vld_r     = retire_ok ? (vld_q & ~oldest_oh) : vld_q;

  always_comb begin
    vld_d = vld_r;
    rd_d  = rd_q;
    hz_d  = hz_q;
    age_d = age_q;
    err_d = err_q;
    if (flush_i) begin
      vld_d = '0;
      hz_d  = '0;
      age_d = '0;
    end else begin
      if (alloc_ok) begin
        vld_d[0] = 1'b1;
        rd_d[0]  = rd_i;
        for (int j = 1; j < DEPTH; j++) begin
          vld_d[j] = vld_r[j-1];
          rd_d[j]  = rd_q[j-1];
        end
      end
      if (overflow || underflow) begin
        err_d = 1'b1;
      end
      if (check_i) begin
        hz_d  = new_hz;
        age_d = new_age;
      end else if (fwd_vld_i) begin
        hz_d  = '0;
        age_d = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstz_i) begin
    if (!rstz_i) begin
      vld_q <= '0;
      rd_q  <= '0;
      hz_q  <= '0;
      age_q <= '0;
      err_q <= 1'b0;
    end else begin
      vld_q <= vld_d;
      rd_q  <= rd_d;
      hz_q  <= hz_d;
      age_q <= age_d;
      err_q <= err_d;
    end
  end

  assign op_hazard_o  = hz_q;
  assign any_hazard_o = |hz_q;
  assign op_age_o     = age_q;
  assign pend_count_o = cnt;
  assign full_o       = full;
  assign err_o        = err_q;

endmodule

// File: tb/tb_kronos_hcu_sb.sv
// Bench for kronos_hcu_sb: directed scenarios then random traffic, checked
// against a queue-based reference model of the pending-write scoreboard.
module tb_kronos_hcu_sb;
  localparam int              DEPTH = 2;
  localparam int              NOPS  = 4;
  localparam int              AW    = 1;
  localparam logic [NOPS-1:0] MASK  = 4'b1010;
`ifdef KRONOS_HCU_RETIRE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk = 1'b0;
  logic               rstz;
  logic               check, fwd_vld, retire, flush, rd_write;
  logic [4:0]         rd, rs1, rs2;
  logic [NOPS-1:0]    op_regrd;
  logic [NOPS-1:0]    op_hazard;
  logic               any_hazard;
  logic [NOPS*AW-1:0] op_age;
  logic [AW:0]        pend_count;
  logic               full, err;

  int n_pass  = 0;
  int n_total = 0;

  int                 q[$];
  logic [NOPS-1:0]    m_hz;
  logic [NOPS*AW-1:0] m_age;
  bit                 m_err;

  kronos_hcu_sb #(.DEPTH(DEPTH), .NOPS(NOPS), .OP_RS2_MASK(MASK)) dut (
    .clk_i(clk), .rstz_i(rstz), .check_i(check), .fwd_vld_i(fwd_vld),
    .retire_i(retire), .flush_i(flush), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2),
    .rd_write_i(rd_write), .op_regrd_i(op_regrd), .op_hazard_o(op_hazard),
    .any_hazard_o(any_hazard), .op_age_o(op_age), .pend_count_o(pend_count),
    .full_o(full), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    q.delete();
    m_hz  = '0;
    m_age = '0;
    m_err = 1'b0;
  endtask

  // Reference: queue front is the youngest write; back is the oldest.
  task automatic model_edge();
    logic [NOPS-1:0]    h;
    logic [NOPS*AW-1:0] a;
    int src;
    int n;
    if (flush) begin
      q.delete();
      m_hz  = '0;
      m_age = '0;
      return;
    end
    n = q.size();
    if (check) begin
      h = '0;
      a = '0;
      for (int i = 0; i < NOPS; i++) begin
        src = MASK[i] ? int'(rs2) : int'(rs1);
        if (op_regrd[i] && src != 0) begin
          for (int k = 0; k < n; k++) begin
            if (BYP && retire && k == n - 1) continue;
            if (q[k] == src) begin
              h[i] = 1'b1;
              a[i*AW +: AW] = AW'(k);
              break;
            end
          end
        end
      end
      m_hz  = h;
      m_age = a;
    end else if (fwd_vld) begin
      m_hz  = '0;
      m_age = '0;
    end
    if (retire) begin
      if (n == 0) m_err = 1'b1;
      else void'(q.pop_back());
    end
    if (check && rd_write && rd != 5'd0) begin
      if (q.size() < DEPTH) q.push_front(int'(rd));
      else m_err = 1'b1;
    end
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    chk({tag, ".hz"},   32'(op_hazard),  32'(m_hz));
    chk({tag, ".any"},  32'(any_hazard), 32'(|m_hz));
    chk({tag, ".age"},  32'(op_age),     32'(m_age));
    chk({tag, ".pend"}, 32'(pend_count), 32'(q.size()));
    chk({tag, ".full"}, 32'(full),       32'(q.size() == DEPTH));
    chk({tag, ".err"},  32'(err),        32'(m_err));
  endtask

  task automatic set_in(bit c, bit f, bit r, bit fl, logic [4:0] d,
                        logic [4:0] s1, logic [4:0] s2, bit w, logic [3:0] rg);
    check = c; fwd_vld = f; retire = r; flush = fl;
    rd = d; rs1 = s1; rs2 = s2; rd_write = w; op_regrd = rg;
  endtask

  task automatic step(string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  initial begin
    rstz = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 4'h0);
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    chk("reset.pend0", 32'(pend_count), 32'd0);
    rstz = 1'b1;

    // Single producer, consumer on rs1 the next cycle.
    set_in(1, 0, 0, 0, 5, 0, 0, 1, 4'h0); step("tp1.alloc");
    set_in(1, 0, 0, 0, 0, 5, 0, 0, 4'h1); step("tp1.use");
    chk("tp1.hz", 32'(op_hazard), 32'h1);
    chk("tp1.any", 32'(any_hazard), 32'h1);
    chk("tp1.age", 32'(op_age), 32'h0);
    chk("tp1.pend", 32'(pend_count), 32'd1);

    // Two producers, every operand slot checked, ages split by rs1/rs2.
    set_in(0, 0, 0, 1, 0, 0, 0, 0, 4'h0); step("tp2.flush");
    set_in(1, 0, 0, 0, 3, 0, 0, 1, 4'h0); step("tp2.a3");
    set_in(1, 0, 0, 0, 7, 0, 0, 1, 4'h0); step("tp2.a7");
    set_in(1, 0, 0, 0, 0, 3, 7, 0, 4'hF); step("tp2.use");
    chk("tp2.hz", 32'(op_hazard), 32'hF);
    chk("tp2.age", 32'(op_age), 32'h5);
    chk("tp2.full", 32'(full), 32'd1);

    // Overflow on a full queue, then drain with two retires.
    set_in(1, 0, 0, 0, 9, 0, 0, 1, 4'h0); step("tp4.ovf");
    chk("tp4.pend", 32'(pend_count), 32'd2);
    chk("tp4.err", 32'(err), 32'd1);
    set_in(0, 0, 1, 0, 0, 0, 0, 0, 4'h0); step("tp4.ret1");
    step("tp4.ret2");
    chk("tp4.pend0", 32'(pend_count), 32'd0);

    // Writes to x0 never allocate.
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 4'h0); step("tp3.x0");
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 4'h1); step("tp3.use");
    chk("tp3.hz", 32'(op_hazard), 32'h0);
    chk("tp3.pend", 32'(pend_count), 32'd0);

    // Producer retires in the same cycle as the consumer check.
    set_in(1, 0, 0, 0, 4, 0, 0, 1, 4'h0); step("tp5.a4");
    set_in(1, 0, 1, 0, 0, 4, 0, 0, 4'h1); step("tp5.use");
    chk("tp5.hz0", 32'(op_hazard[0]), BYP ? 32'd0 : 32'd1);
    chk("tp5.pend", 32'(pend_count), 32'd0);

    // Flush beats a simultaneous check; fwd_vld afterwards keeps zeros.
    set_in(1, 0, 0, 0, 6, 0, 0, 1, 4'h0); step("tp6.a6");
    set_in(1, 0, 0, 0, 0, 6, 0, 0, 4'h1); step("tp6.use");
    chk("tp6.hz1", 32'(op_hazard), 32'h1);
    set_in(1, 0, 0, 1, 6, 6, 6, 1, 4'hF); step("tp6.flush");
    chk("tp6.hz0", 32'(op_hazard), 32'h0);
    chk("tp6.pend", 32'(pend_count), 32'd0);
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 4'h0); step("tp6.fwd");
    chk("tp6.fwdhz", 32'(op_hazard), 32'h0);

    // Fwd_vld alone clears a latched hazard.
    set_in(1, 0, 0, 0, 2, 0, 0, 1, 4'h0); step("fwd.a2");
    set_in(1, 0, 0, 0, 0, 2, 2, 0, 4'hF); step("fwd.use");
    set_in(0, 1, 0, 0, 0, 0, 0, 0, 4'h0); step("fwd.clr");
    chk("fwd.any", 32'(any_hazard), 32'd0);

    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        rstz = 1'b0;
        #2;
        model_reset();
        check_all("async_rst");
        @(negedge clk);
        rstz = 1'b1;
      end
      set_in(1'($urandom_range(1, 0)), ($urandom % 4) == 0, ($urandom % 3) == 0,
             ($urandom % 20) == 0, 5'($urandom % 6), 5'($urandom % 6),
             5'($urandom % 6), ($urandom % 4) != 0, 4'($urandom));
      step($sformatf("rnd%0d", c));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
